mem_port_arbiter: RTL and testbench

- Shares the single-ported synchronous memory/MMIO path (SRAM behind the MMU, UART registers) between the core's instruction-fetch port and its load/store port.
- Each cycle it grants at most one requester, drives the shared memory port, and routes the one-cycle-latency read response back to the owner.
- Data wins by default; a starvation counter guarantees fetch forward progress.
- A fetch flush input discards in-flight fetch responses on taken branches/jumps.

---
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported synchronous memory between instruction fetch and load/store.
// Data has priority; a starvation counter forces a fetch grant after STARVE_LIMIT denied cycles.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  // load/store port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [2:0]        d_fn3,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  // shared memory port
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_fn3,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [2:0]        starve_cnt
);

  localparam logic [2:0] LIMIT      = 3'(STARVE_LIMIT);
  localparam logic [2:0] FETCH_FN3  = 3'b010;
  localparam logic [2:0] CNT_MAX    = 3'd7;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_D_RD,
    OWN_D_WR
  } owner_e;

  owner_e     resp_owner;
  owner_e     owner_next;
  logic [2:0] starve_q;
  logic [2:0] starve_next;
  logic       force_if;
  logic       fetch_live;

  assign starve_cnt = starve_q;

  // Grants are purely combinational so a request can be accepted in the cycle it appears.
  always_comb begin
    force_if   = (starve_q >= LIMIT);
    fetch_live = if_req & ~if_flush;
    d_gnt      = d_req & ~rst & ~(force_if & fetch_live);
    if_gnt     = fetch_live & ~rst & ~d_gnt;
  end

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_fn3   = 3'b000;
    if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_fn3   = d_fn3;
    end else if (if_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = if_addr;
      mem_fn3   = FETCH_FN3;
    end
  end

  always_comb begin
    owner_next = OWN_NONE;
    if (d_gnt) begin
      owner_next = d_we ? OWN_D_WR : OWN_D_RD;
    end else if (if_gnt) begin
      owner_next = OWN_IF;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_owner <= OWN_NONE;
    end else begin
      resp_owner <= owner_next;
    end
  end

  // Read data is forwarded straight from memory; a flush in the response cycle hides a stale fetch.
  always_comb begin
    if_rvalid = 1'b0;
    if_rdata  = '0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    unique case (resp_owner)
      OWN_IF: begin
        if (!if_flush) begin
          if_rvalid = 1'b1;
          if_rdata  = mem_rdata;
        end
      end
      OWN_D_RD: begin
        d_rvalid = 1'b1;
        d_rdata  = mem_rdata;
      end
      OWN_D_WR: begin
        d_rvalid = 1'b1;
      end
      default: ;
    endcase
  end

  // Counts consecutive cycles a live fetch request was denied; saturates rather than wrapping.
  always_comb begin
    starve_next = 3'd0;
    if (if_req && !if_gnt && !if_flush) begin
      starve_next = (starve_q == CNT_MAX) ? CNT_MAX : starve_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= 3'd0;
    end else begin
      starve_q <= starve_next;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written corner
// sequences, then randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_flush = 1'b0;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [2:0]  d_fn3 = '0;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_fn3;
  logic [31:0] mem_rdata = '0;
  logic [2:0]  starve_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_fn3(d_fn3),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_fn3(mem_fn3), .mem_rdata(mem_rdata), .starve_cnt(starve_cnt)
  );

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_fn3;
    logic [31:0] mem_rdata;
  } in_t;

  typedef struct {
    logic        if_gnt;
    logic        d_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_fn3;
    logic [2:0]  starve_cnt;
  } out_t;

  typedef struct {
    in_t  stim;
    out_t exp;
  } vec_t;

  // One outstanding memory access as seen by the reference model.
  typedef struct {
    bit to_fetch;
    bit is_store;
  } resp_t;

  function automatic in_t mk_in(logic ir, logic [31:0] ia, logic fl, logic dr, logic we,
                                logic [31:0] da, logic [31:0] dw, logic [2:0] fn,
                                logic [31:0] mr);
    in_t v;
    v.if_req = ir; v.if_addr = ia; v.if_flush = fl;
    v.d_req = dr; v.d_we = we; v.d_addr = da; v.d_wdata = dw; v.d_fn3 = fn;
    v.mem_rdata = mr;
    return v;
  endfunction

  function automatic out_t mk_out(logic ig, logic dg, logic iv, logic [31:0] ird,
                                  logic dv, logic [31:0] drd, logic me, logic mw,
                                  logic [31:0] ma, logic [31:0] mwd, logic [2:0] mf,
                                  logic [2:0] sc);
    out_t o;
    o.if_gnt = ig; o.d_gnt = dg; o.if_rvalid = iv; o.if_rdata = ird;
    o.d_rvalid = dv; o.d_rdata = drd; o.mem_en = me; o.mem_we = mw;
    o.mem_addr = ma; o.mem_wdata = mwd; o.mem_fn3 = mf; o.starve_cnt = sc;
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input out_t e);
    check({tag, ".if_gnt"},     64'(if_gnt),     64'(e.if_gnt));
    check({tag, ".d_gnt"},      64'(d_gnt),      64'(e.d_gnt));
    check({tag, ".if_rvalid"},  64'(if_rvalid),  64'(e.if_rvalid));
    check({tag, ".if_rdata"},   64'(if_rdata),   64'(e.if_rdata));
    check({tag, ".d_rvalid"},   64'(d_rvalid),   64'(e.d_rvalid));
    check({tag, ".d_rdata"},    64'(d_rdata),    64'(e.d_rdata));
    check({tag, ".mem_en"},     64'(mem_en),     64'(e.mem_en));
    check({tag, ".mem_we"},     64'(mem_we),     64'(e.mem_we));
    check({tag, ".mem_addr"},   64'(mem_addr),   64'(e.mem_addr));
    check({tag, ".mem_wdata"},  64'(mem_wdata),  64'(e.mem_wdata));
    check({tag, ".mem_fn3"},    64'(mem_fn3),    64'(e.mem_fn3));
    check({tag, ".starve_cnt"}, 64'(starve_cnt), 64'(e.starve_cnt));
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later, well away from posedge.
  task automatic apply(input in_t v);
    @(negedge clk);
    if_req = v.if_req; if_addr = v.if_addr; if_flush = v.if_flush;
    d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
    d_fn3 = v.d_fn3; mem_rdata = v.mem_rdata;
    #1;
  endtask

  vec_t  vecs[9];
  out_t  zero_out;
  in_t   idle_in;
  resp_t resp_q[$];

  initial begin
    zero_out = mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    idle_in  = mk_in(0, 0, 0, 0, 0, 0, 0, 3'b000, 0);

    // single fetch, store, load, then fetch/load/fetch alternation with 0xA/0xB/0xC
    vecs[0] = '{mk_in(1, 32'h8000_0000, 0, 0, 0, 0, 0, 3'b000, 32'h0),
                mk_out(1, 0, 0, 0, 0, 0, 1, 0, 32'h8000_0000, 0, 3'b010, 0)};
    vecs[1] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 3'b000, 32'h0000_0013),
                mk_out(0, 0, 1, 32'h0000_0013, 0, 0, 0, 0, 0, 0, 3'b000, 0)};
    vecs[2] = '{mk_in(0, 0, 0, 1, 1, 32'h1000_0008, 32'h41, 3'b000, 32'hdead_beef),
                mk_out(0, 1, 0, 0, 0, 0, 1, 1, 32'h1000_0008, 32'h41, 3'b000, 0)};
    vecs[3] = '{mk_in(0, 0, 0, 1, 0, 32'h1000_0004, 32'h55, 3'b010, 32'h7777_7777),
                mk_out(0, 1, 0, 0, 1, 0, 1, 0, 32'h1000_0004, 32'h55, 3'b010, 0)};
    vecs[4] = '{mk_in(1, 32'h8000_0004, 0, 0, 0, 0, 0, 3'b000, 32'h1234_5678),
                mk_out(1, 0, 0, 0, 1, 32'h1234_5678, 1, 0, 32'h8000_0004, 0, 3'b010, 0)};
    vecs[5] = '{mk_in(0, 0, 0, 1, 0, 32'h1000_0000, 0, 3'b100, 32'h0000_000A),
                mk_out(0, 1, 1, 32'hA, 0, 0, 1, 0, 32'h1000_0000, 0, 3'b100, 0)};
    vecs[6] = '{mk_in(1, 32'h8000_0008, 0, 0, 0, 0, 0, 3'b000, 32'h0000_000B),
                mk_out(1, 0, 0, 0, 1, 32'hB, 1, 0, 32'h8000_0008, 0, 3'b010, 0)};
    vecs[7] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 3'b000, 32'h0000_000C),
                mk_out(0, 0, 1, 32'hC, 0, 0, 0, 0, 0, 0, 3'b000, 0)};
    vecs[8] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 3'b000, 32'h0000_000D),
                zero_out};

    // power-on reset with requests already asserted: everything must stay quiet
    apply(mk_in(1, 32'h8000_0000, 0, 1, 1, 32'h10, 32'h20, 3'b001, 32'hffff_ffff));
    check_out("por", zero_out);
    apply(idle_in);
    rst = 1'b0;
    #1;
    check_out("por_release", zero_out);

    for (int i = 0; i < 9; i++) begin
      apply(vecs[i].stim);
      check_out($sformatf("vec%0d", i), vecs[i].exp);
    end

    // continuous contention: 4 data grants, then one forced fetch, repeating every 5 cycles
    for (int k = 0; k < 10; k++) begin
      apply(mk_in(1, 32'h8000_0100, 0, 1, 1, 32'h1000_0010, 32'h5a, 3'b010, 32'h0));
      check($sformatf("starve%0d.d_gnt", k),  64'(d_gnt),  64'((k % 5) != 4));
      check($sformatf("starve%0d.if_gnt", k), 64'(if_gnt), 64'((k % 5) == 4));
      check($sformatf("starve%0d.cnt", k),    64'(starve_cnt), 64'(k % 5));
      if (k > 0) check($sformatf("starve%0d.d_rvalid", k), 64'(d_rvalid), 64'(((k - 1) % 5) != 4));
    end
    apply(mk_in(0, 0, 0, 0, 0, 0, 0, 3'b000, 32'h0000_0042));
    check("starve_tail.if_rvalid", 64'(if_rvalid), 64'(1));
    check("starve_tail.cnt", 64'(starve_cnt), 64'(0));

    // flush: fetch granted, then flushed in the response cycle while data is still served
    apply(mk_in(1, 32'h8000_0200, 0, 0, 0, 0, 0, 3'b000, 32'h0));
    check_out("flush_n", mk_out(1, 0, 0, 0, 0, 0, 1, 0, 32'h8000_0200, 0, 3'b010, 0));
    apply(mk_in(1, 32'h8000_0300, 1, 1, 0, 32'h1000_0020, 0, 3'b010, 32'h0000_0099));
    check_out("flush_n1", mk_out(0, 1, 0, 0, 0, 0, 1, 0, 32'h1000_0020, 0, 3'b010, 0));
    apply(mk_in(1, 32'h8000_0300, 0, 0, 0, 0, 0, 3'b000, 32'h0000_0005));
    check_out("flush_n2", mk_out(1, 0, 0, 0, 1, 32'h5, 1, 0, 32'h8000_0300, 0, 3'b010, 0));
    apply(mk_in(0, 0, 0, 0, 0, 0, 0, 3'b000, 32'h0000_0006));
    check_out("flush_n3", mk_out(0, 0, 1, 32'h6, 0, 0, 0, 0, 0, 0, 3'b000, 0));

    // reset mid-stream with a load response owed and a non-zero starvation count
    apply(mk_in(1, 32'h8000_0400, 0, 1, 0, 32'h1000_0030, 0, 3'b010, 32'h0));
    check("rst_pre0.d_gnt", 64'(d_gnt), 64'(1));
    apply(mk_in(1, 32'h8000_0400, 0, 1, 0, 32'h1000_0030, 0, 3'b010, 32'h0));
    check("rst_pre1.cnt", 64'(starve_cnt), 64'(1));
    @(negedge clk);
    rst = 1'b1;
    mem_rdata = 32'hcafe_f00d;
    #1;
    check_out("rst_mid", zero_out);
    apply(mk_in(1, 32'h8000_0400, 0, 1, 0, 32'h1000_0030, 0, 3'b010, 32'hcafe_f00d));
    check_out("rst_hold", zero_out);
    @(negedge clk);
    rst = 1'b0;
    if_req = 1'b0; d_req = 1'b0; mem_rdata = 32'h1234;
    #1;
    check_out("rst_after", zero_out);

    run_random(600);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Randomized traffic. Requests are held until the model says they were granted (or
  // occasionally withdrawn), flush and reset are sprinkled in, and every output is compared.
  task automatic run_random(input int cycles);
    int   denied = 0;
    bit   prev_if_gnt = 1'b0;
    bit   prev_d_gnt  = 1'b0;
    in_t  s;
    out_t e;
    resp_t r;
    s = idle_in;
    resp_q.delete();
    for (int c = 0; c < cycles; c++) begin
      bit want_fetch;
      bit do_rst;
      if (!s.if_req || prev_if_gnt || $urandom_range(0, 15) == 0) begin
        s.if_req  = ($urandom_range(0, 9) < 6);
        s.if_addr = $urandom() & 32'hffff_fffc;
      end
      if (!s.d_req || prev_d_gnt || $urandom_range(0, 15) == 0) begin
        s.d_req   = ($urandom_range(0, 9) < 5);
        s.d_we    = $urandom_range(0, 1) == 1;
        s.d_addr  = $urandom();
        s.d_wdata = $urandom();
        s.d_fn3   = 3'($urandom_range(0, 7));
      end
      s.if_flush  = ($urandom_range(0, 9) == 0);
      s.mem_rdata = $urandom();
      do_rst = (c == 0) || ($urandom_range(0, 59) == 0);

      @(negedge clk);
      rst = do_rst;
      if_req = s.if_req; if_addr = s.if_addr; if_flush = s.if_flush;
      d_req = s.d_req; d_we = s.d_we; d_addr = s.d_addr; d_wdata = s.d_wdata;
      d_fn3 = s.d_fn3; mem_rdata = s.mem_rdata;
      #1;

      // reference model: reset wipes everything immediately
      if (do_rst) begin
        resp_q.delete();
        denied = 0;
      end
      want_fetch = s.if_req && !s.if_flush;
      e = zero_out;
      e.starve_cnt = 3'(denied);
      if (!do_rst) begin
        if (s.d_req && !(denied >= LIMIT && want_fetch)) e.d_gnt = 1'b1;
        else if (want_fetch) e.if_gnt = 1'b1;
      end
      if (e.d_gnt) begin
        e.mem_en = 1'b1; e.mem_we = s.d_we; e.mem_addr = s.d_addr;
        e.mem_wdata = s.d_wdata; e.mem_fn3 = s.d_fn3;
      end else if (e.if_gnt) begin
        e.mem_en = 1'b1; e.mem_addr = s.if_addr; e.mem_fn3 = 3'b010;
      end
      if (resp_q.size() > 0) begin
        r = resp_q.pop_front();
        if (r.to_fetch) begin
          if (!s.if_flush) begin
            e.if_rvalid = 1'b1;
            e.if_rdata  = s.mem_rdata;
          end
        end else begin
          e.d_rvalid = 1'b1;
          e.d_rdata  = r.is_store ? 32'h0 : s.mem_rdata;
        end
      end
      check_out($sformatf("rnd%0d", c), e);

      // advance model to the next cycle
      if (e.d_gnt)  resp_q.push_back('{to_fetch: 1'b0, is_store: s.d_we});
      if (e.if_gnt) resp_q.push_back('{to_fetch: 1'b1, is_store: 1'b0});
      if (do_rst) denied = 0;
      else if (s.if_req && !e.if_gnt && !s.if_flush) denied = (denied >= 7) ? 7 : denied + 1;
      else denied = 0;
      prev_if_gnt = e.if_gnt;
      prev_d_gnt  = e.d_gnt;
    end
    @(negedge clk);
    rst = 1'b0;
    if_req = 1'b0; d_req = 1'b0; if_flush = 1'b0;
  endtask

endmodule
